uart_rx_frame_ctrl: RTL and testbench



---
 rtl/uart_rx_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: collects NUM_OPS little-endian operands plus a command byte.
// Optional inter-byte timeout with frame_err is built when UART_RX_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
  parameter int OP_BYTES     = 2,
  parameter int NUM_OPS      = 2,
  parameter int BYTE_TIMEOUT = 1000000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                rx_ready,
  input  logic [7:0]                          rx_data,
  input  logic                                tx_done,
  output logic [NUM_OPS*OP_BYTES*8-1:0]       operands_o,
  output logic [7:0]                          cmd_o,
  output logic [$clog2(NUM_OPS+1)-1:0]        op_idx_o,
  output logic                                frame_valid,
  output logic                                trigger_tx,
  output logic                                busy,
  output logic                                overrun,
  output logic                                frame_err
);

  localparam int FW = NUM_OPS * OP_BYTES * 8;
  localparam int IW = $clog2(NUM_OPS + 1);
  localparam int BW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

  typedef enum logic [2:0] {
    COLLECT,
    CMD,
    EXEC,
    TRIG,
    WAIT_TX
  } state_t;

  state_t          state;
  logic [BW-1:0]   byte_idx;
  logic [IW-1:0]   op_idx;
  logic [FW-1:0]   staging;
  logic            last_byte;
  logic            last_op;

  assign last_byte = (byte_idx == BW'(OP_BYTES - 1));
  assign last_op   = (op_idx == IW'(NUM_OPS - 1));
  assign op_idx_o  = op_idx;

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          partial;
  logic          accept;

  assign partial = ((state == COLLECT) &&
                    ((byte_idx != '0) || (op_idx != '0))) ||
                   (state == CMD);
  assign accept  = rx_ready && ((state == COLLECT) || (state == CMD));
`else
  assign frame_err = 1'b0;
`endif

  // Frame FSM: byte staging, commit, pulses, busy and timeout abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      byte_idx    <= '0;
      op_idx      <= '0;
      staging     <= '0;
      operands_o  <= '0;
      cmd_o       <= '0;
      frame_valid <= 1'b0;
      trigger_tx  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
      frame_err   <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      trigger_tx  <= 1'b0;
      overrun     <= rx_ready && busy;
`ifdef UART_RX_FRAME_TIMEOUT_EN
      frame_err   <= 1'b0;
`endif
      unique case (state)
        COLLECT: begin
          if (rx_ready) begin
            // bytes enter at the top; after a full frame byte 0 sits at the LSB
            staging <= FW'({rx_data, staging} >> 8);
            if (last_byte) begin
              byte_idx <= '0;
              op_idx   <= op_idx + IW'(1);
              if (last_op) state <= CMD;
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        CMD: begin
          if (rx_ready) begin
            operands_o  <= staging;
            cmd_o       <= rx_data;
            busy        <= 1'b1;
            frame_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          trigger_tx <= 1'b1;
          state      <= TRIG;
        end
        TRIG: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            busy     <= 1'b0;
            byte_idx <= '0;
            op_idx   <= '0;
            state    <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
`ifdef UART_RX_FRAME_TIMEOUT_EN
      if (accept) begin
        tcnt <= '0;
      end else if (partial) begin
        if (tcnt == TW'(BYTE_TIMEOUT - 1)) begin
          tcnt      <= '0;
          frame_err <= 1'b1;
          byte_idx  <= '0;
          op_idx    <= '0;
          state     <= COLLECT;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: randomized frames against a byte-list reference model.
// Expected pulses are queued by cycle and popped by a negedge monitor.
module tb_uart_rx_frame_ctrl;

  localparam int OB = 3;
  localparam int NO = 3;
  localparam int BT = 16;
  localparam int NB = OB * NO;
  localparam int FW = NB * 8;
  localparam int IW = $clog2(NO + 1);
`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          tx_done;
  logic [FW-1:0] operands_o;
  logic [7:0]    cmd_o;
  logic [IW-1:0] op_idx_o;
  logic          frame_valid;
  logic          trigger_tx;
  logic          busy;
  logic          overrun;
  logic          frame_err;

  uart_rx_frame_ctrl #(
    .OP_BYTES(OB),
    .NUM_OPS(NO),
    .BYTE_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .tx_done(tx_done),
    .operands_o(operands_o),
    .cmd_o(cmd_o),
    .op_idx_o(op_idx_o),
    .frame_valid(frame_valid),
    .trigger_tx(trigger_tx),
    .busy(busy),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit in_reset = 1'b1;

  // reference model: bytes of the frame in progress and last committed frame
  logic [7:0]    q[$];
  bit            m_busy = 1'b0;
  int            ec = 0;
  int            idle_n = 0;
  logic [FW-1:0] exp_ops = '0;
  logic [7:0]    exp_cmd = '0;
  // 0 frame_valid, 1 trigger_tx, 2 overrun, 3 frame_err: expected cycles
  int            evq[4][$];
  int            gap = 0;

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_idx();
    int n;
    n = q.size() / OB;
    if (n > NO) n = NO;
    return n;
  endfunction

  task automatic ev(int k, string nm, logic sig);
    while (evq[k].size() > 0 && evq[k][0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s missing act=0 exp=1 at cyc %0d (now %0d)",
               nm, evq[k][0], cyc);
      void'(evq[k].pop_front());
    end
    if (sig) begin
      checks++;
      if (evq[k].size() > 0 && evq[k][0] == cyc) begin
        void'(evq[k].pop_front());
      end else begin
        errors++;
        $display("FAIL %s unexpected act=1 exp=0 cyc=%0d", nm, cyc);
      end
    end
  endtask

  // edge E = cyc just after the clock edge that sampled these inputs
  task automatic model_step(bit rr, logic [7:0] rd, bit td);
    int e;
    e = cyc;
    if (m_busy) begin
      if (rr) evq[2].push_back(e);
      if (td && e >= ec + 3) m_busy = 1'b0;
    end else if (rr) begin
      q.push_back(rd);
      idle_n = 0;
      if (q.size() == NB + 1) begin
        exp_ops = '0;
        for (int i = 0; i < NB; i++) exp_ops[i*8 +: 8] = q[i];
        exp_cmd = q[NB];
        evq[0].push_back(e);
        evq[1].push_back(e + 1);
        m_busy = 1'b1;
        ec = e;
        q.delete();
      end
    end else if (TO_EN && q.size() > 0) begin
      idle_n++;
      if (idle_n == BT) begin
        evq[3].push_back(e);
        q.delete();
        idle_n = 0;
      end
    end
  endtask

  task automatic cyc1(bit rr, logic [7:0] rd, bit td);
    rx_ready = rr;
    rx_data  = rd;
    tx_done  = td;
    @(posedge clk);
    #1;
    model_step(rr, rd, td);
    rx_ready = 1'b0;
    tx_done  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc1(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(logic [7:0] b);
    cyc1(1'b1, b, 1'b0);
  endtask

  task automatic send_frame();
    for (int i = 0; i <= NB; i++) send(8'($urandom));
  endtask

  task automatic finish_tx();
    for (int g = 0; g < 10 && m_busy; g++) begin
      if (cyc >= ec + 2) cyc1(1'b0, 8'h00, 1'b1);
      else cyc1(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    #1;
    reset = 1'b0;
    q.delete();
    m_busy  = 1'b0;
    idle_n  = 0;
    gap     = 0;
    exp_ops = '0;
    exp_cmd = '0;
    for (int k = 0; k < 4; k++) evq[k].delete();
    #1;
    chk("rst_operands", operands_o, '0);
    chk("rst_cmd", cmd_o, '0);
    chk("rst_op_idx", op_idx_o, '0);
    chk("rst_busy", busy, '0);
    chk("rst_frame_valid", frame_valid, '0);
    chk("rst_trigger_tx", trigger_tx, '0);
    chk("rst_overrun", overrun, '0);
    chk("rst_frame_err", frame_err, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_reset = 1'b0;
  endtask

  // monitor: levels against the model, pulses against the event queues
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("busy", busy, m_busy);
      if (!m_busy) chk("op_idx", op_idx_o, exp_idx());
      chk("operands", operands_o, exp_ops);
      chk("cmd", cmd_o, exp_cmd);
      ev(0, "frame_valid", frame_valid);
      ev(1, "trigger_tx", trigger_tx);
      ev(2, "overrun", overrun);
      ev(3, "frame_err", frame_err);
    end
  end

  initial begin
    bit rr;
    bit td;
    int sel;
    reset    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    tx_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < NB; i++) send(8'((i + 1) * 8'h11));
    send(8'hA5);
    idle(2);
    chk("pack72", operands_o, 72'h998877665544332211);
    chk("cmd_a5", cmd_o, 8'hA5);

    send(8'h99);
    finish_tx();
    cyc1(1'b0, 8'h00, 1'b1);
    send(8'h01);
    cyc1(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < NB; i++) send(8'($urandom));
    finish_tx();

    send_frame();
    idle(2);
    cyc1(1'b1, 8'h5A, 1'b1);
    send_frame();
    finish_tx();

    if (TO_EN) begin
      send(8'hC1);
      send(8'hC2);
      idle(BT);
      send_frame();
      finish_tx();
      send(8'hD1);
      idle(BT - 1);
      send(8'hD2);
      idle(BT + 2);
    end

    send(8'hE1);
    send(8'hE2);
    send(8'hE3);
    do_reset();
    send_frame();
    finish_tx();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else if (m_busy) begin
        rr = ($urandom_range(0, 5) == 0);
        if (cyc >= ec + 2) td = ($urandom_range(0, 3) == 0);
        else td = ($urandom_range(0, 9) == 0);
        cyc1(rr, 8'($urandom), td);
      end else if (gap > 0) begin
        gap--;
        cyc1(1'b0, 8'h00, $urandom_range(0, 19) == 0);
      end else begin
        send(8'($urandom));
        sel = $urandom_range(0, 9);
        if (sel < 5) gap = 0;
        else if (sel < 8) gap = $urandom_range(1, 4);
        else gap = BT - 2 + $urandom_range(0, 3);
      end
    end

    finish_tx();
    idle(4);
    for (int k = 0; k < 4; k++) chk("pending_events", evq[k].size(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
